// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game judge.
// Used by pair_judge and reveal_timer.
package memory_game_pkg;

  localparam int N_CELLS = 16;

  typedef logic [3:0] cell_idx_t;
  typedef logic [3:0] card_label_t;

  typedef enum logic [2:0] {
    WAIT1   = 3'd0,
    WAIT2   = 3'd1,
    REVEAL  = 3'd2,
    RESOLVE = 3'd3,
    DONE    = 3'd4
  } judge_state_t;

  typedef logic [1:0] winner_t;

  localparam winner_t W_NONE = 2'b00;
  localparam winner_t W_J1   = 2'b01;
  localparam winner_t W_J2   = 2'b10;
  localparam winner_t W_TIE  = 2'b11;

  typedef struct packed {
    cell_idx_t   idx;
    card_label_t label;
  } pick_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reveal_timer.sv
// Loadable down-counter that stops at zero.
// Serves as reveal window and turn idle counter.
module reveal_timer
  import memory_game_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (en && !zero) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/pair_judge.sv
// Judges card pairs, keeps scores, turn and end of game.
// Optional turn forfeit on idle: define TURN_TIMEOUT_EN.
module pair_judge
  import memory_game_pkg::*;
#(
  parameter int N_PAIRS       = 8,
  parameter int REVEAL_CYCLES = 25_000_000,
  parameter int TURN_TIMEOUT  = 250_000_000,
  localparam int SW = $clog2(N_PAIRS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pick_valid,
  input  logic [3:0]    pick_idx,
  input  logic [3:0]    pick_label,
  output logic          pick_ready,
  output logic          match,
  output logic          hide_valid,
  output logic [3:0]    hide_idx_a,
  output logic [3:0]    hide_idx_b,
  output logic          player,
  output logic [SW-1:0] score_j1,
  output logic [SW-1:0] score_j2,
  output logic          finish,
  output logic [1:0]    winner,
  output logic [2:0]    state
);

  localparam int RW = cnt_w(REVEAL_CYCLES);
  localparam logic [RW-1:0] R_LD =
    RW'(REVEAL_CYCLES - 1);
  localparam logic [SW-1:0] NP = SW'(N_PAIRS);
  localparam logic [SW:0] NP1 = (SW+1)'(N_PAIRS);

  judge_state_t st;
  pick_t        pa;
  pick_t        pb;

  logic          waiting;
  logic          accept;
  logic          new_b;
  logic          same;
  logic [RW-1:0] rt_val;
  logic          rt_zero;
  logic [SW-1:0] j1_n;
  logic [SW-1:0] j2_n;
  logic [SW:0]   sum_n;
  winner_t       win_n;

  assign state   = st;
  assign waiting = (st == WAIT1) || (st == WAIT2);
  assign pick_ready = waiting;
  assign accept  = pick_valid && waiting;
  assign new_b   = pick_valid && (st == WAIT2) &&
                   (pick_idx != pa.idx);
  assign same    = (pa.label == pb.label);

  reveal_timer #(.W(RW)) u_reveal (
    .clk      (clk),
    .rst      (rst),
    .load     (new_b),
    .load_val (R_LD),
    .en       (st == REVEAL),
    .value    (rt_val),
    .zero     (rt_zero)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int TW = cnt_w(TURN_TIMEOUT);
  localparam logic [TW-1:0] T_LD =
    TW'(TURN_TIMEOUT - 1);

  logic [TW-1:0] to_val;
  logic          to_zero;
  logic          to_fire;

  // Reload on any accepted pick and on every way back into WAIT1.
  assign to_fire = waiting && to_zero && !accept;

  reveal_timer #(.W(TW), .RST_VAL(T_LD)) u_idle (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || to_fire ||
               (st == RESOLVE)),
    .load_val (T_LD),
    .en       (waiting),
    .value    (to_val),
    .zero     (to_zero)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TURN_TIMEOUT != 0);
`endif

  always_comb begin
    j1_n = score_j1;
    j2_n = score_j2;
    if (same) begin
      if (!player) begin
        j1_n = (score_j1 == NP) ? score_j1
                                : score_j1 + 1'b1;
      end else begin
        j2_n = (score_j2 == NP) ? score_j2
                                : score_j2 + 1'b1;
      end
    end
    sum_n = {1'b0, j1_n} + {1'b0, j2_n};
    unique case (1'b1)
      (j1_n > j2_n): win_n = W_J1;
      (j2_n > j1_n): win_n = W_J2;
      default:       win_n = W_TIE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= WAIT1;
      pa         <= '0;
      pb         <= '0;
      match      <= 1'b0;
      hide_valid <= 1'b0;
      hide_idx_a <= '0;
      hide_idx_b <= '0;
      player     <= 1'b0;
      score_j1   <= '0;
      score_j2   <= '0;
      finish     <= 1'b0;
      winner     <= W_NONE;
    end else begin
      match      <= 1'b0;
      hide_valid <= 1'b0;
      unique case (st)
        WAIT1: begin
          if (pick_valid) begin
            pa <= '{pick_idx, pick_label};
            st <= WAIT2;
          end
`ifdef TURN_TIMEOUT_EN
          else if (to_fire) begin
            player <= ~player;
          end
`endif
        end
        WAIT2: begin
          if (new_b) begin
            pb <= '{pick_idx, pick_label};
            st <= REVEAL;
          end
`ifdef TURN_TIMEOUT_EN
          else if (to_fire) begin
            hide_valid <= 1'b1;
            hide_idx_a <= pa.idx;
            hide_idx_b <= pa.idx;
            player     <= ~player;
            st         <= WAIT1;
          end
`endif
        end
        REVEAL: begin
          if (rt_zero) st <= RESOLVE;
        end
        RESOLVE: begin
          hide_idx_a <= pa.idx;
          hide_idx_b <= pb.idx;
          if (same) begin
            match    <= 1'b1;
            score_j1 <= j1_n;
            score_j2 <= j2_n;
            if (sum_n == NP1) begin
              st     <= DONE;
              finish <= 1'b1;
              winner <= win_n;
            end else begin
              st <= WAIT1;
            end
          end else begin
            hide_valid <= 1'b1;
            player     <= ~player;
            st         <= WAIT1;
          end
        end
        DONE: begin
          finish <= 1'b1;
        end
        default: st <= WAIT1;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_judge.sv
// Directed self-checking bench for pair_judge.
// Small board: 2 pairs, 4-cycle reveal, 10-cycle idle timeout.
module tb_pair_judge;

  logic       clk;
  logic       rst;
  logic       pick_valid;
  logic [3:0] pick_idx;
  logic [3:0] pick_label;
  logic       pick_ready;
  logic       match;
  logic       hide_valid;
  logic [3:0] hide_idx_a;
  logic [3:0] hide_idx_b;
  logic       player;
  logic [1:0] score_j1;
  logic [1:0] score_j2;
  logic       finish;
  logic [1:0] winner;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  logic seen;

  pair_judge #(
    .N_PAIRS       (2),
    .REVEAL_CYCLES (4),
    .TURN_TIMEOUT  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx),
    .pick_label (pick_label),
    .pick_ready (pick_ready),
    .match      (match),
    .hide_valid (hide_valid),
    .hide_idx_a (hide_idx_a),
    .hide_idx_b (hide_idx_b),
    .player     (player),
    .score_j1   (score_j1),
    .score_j2   (score_j2),
    .finish     (finish),
    .winner     (winner),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input logic [3:0] i,
                      input logic [3:0] l);
    pick_valid = 1'b1;
    pick_idx   = i;
    pick_label = l;
    tick();
    pick_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_label = '0;
    do_reset();

    chk("rst_state", state, 0);
    chk("rst_ready", pick_ready, 1);
    chk("rst_player", player, 0);
    chk("rst_scores", {score_j1, score_j2}, 0);
    chk("rst_fin_win", {finish, winner}, 0);
    chk("rst_pulses", {match, hide_valid}, 0);

    pick(4'd0, 4'd1);
    chk("m_wait2", state, 1);
    pick(4'd13, 4'd1);
    chk("m_reveal", state, 2);
    repeat (4) tick();
    chk("m_resolve", state, 3);
    chk("m_early", match, 0);
    tick();
    chk("m_match", match, 1);
    chk("m_hide0", hide_valid, 0);
    chk("m_idx", {hide_idx_a, hide_idx_b}, 8'h0d);
    chk("m_score", score_j1, 1);
    chk("m_player", player, 0);
    chk("m_state", state, 0);
    tick();
    chk("m_pulse1", match, 0);

    pick(4'd1, 4'd3);
    pick(4'd2, 4'd2);
    repeat (5) tick();
    chk("mm_hide", hide_valid, 1);
    chk("mm_match0", match, 0);
    chk("mm_idx", {hide_idx_a, hide_idx_b}, 8'h12);
    chk("mm_player", player, 1);
    chk("mm_scores", {score_j1, score_j2}, 4'b0100);
    tick();
    chk("mm_pulse1", hide_valid, 0);

    pick(4'd5, 4'd4);
    chk("rp_first", state, 1);
    pick(4'd5, 4'd4);
    chk("rp_same", state, 1);
    pick(4'd8, 4'd6);
    chk("rp_reveal", state, 2);
    pick_valid = 1'b1;
    pick_idx   = 4'd9;
    pick_label = 4'd6;
    chk("rp_ready0", pick_ready, 0);
    repeat (5) tick();
    pick_valid = 1'b0;
    chk("rp_hide", hide_valid, 1);
    chk("rp_idx", {hide_idx_a, hide_idx_b}, 8'h58);
    chk("rp_player", player, 0);
    chk("rp_state", state, 0);

    pick(4'd3, 4'd7);
    pick(4'd4, 4'd7);
    tick();
    rst = 1'b0;
    #1;
    chk("rr_async", state, 0);
    tick();
    rst = 1'b1;
    seen = 1'b0;
    repeat (7) begin
      tick();
      if (match || hide_valid) seen = 1'b1;
    end
    chk("rr_nopulse", seen, 0);
    chk("rr_state", state, 0);
    chk("rr_scores", {score_j1, score_j2}, 0);

    pick(4'd0, 4'd1);
    pick(4'd1, 4'd1);
    repeat (5) tick();
    chk("eg_match1", match, 1);
    chk("eg_fin0", finish, 0);
    pick(4'd2, 4'd2);
    pick(4'd3, 4'd2);
    repeat (5) tick();
    chk("eg_match2", match, 1);
    chk("eg_score", score_j1, 2);
    chk("eg_finish", finish, 1);
    chk("eg_winner", winner, 2'b01);
    chk("eg_state", state, 4);
    pick_valid = 1'b1;
    pick_idx   = 4'd6;
    pick_label = 4'd3;
    repeat (3) tick();
    pick_valid = 1'b0;
    chk("eg_ready0", pick_ready, 0);
    chk("eg_hold", {state, finish}, 4'b1001);

`ifdef TURN_TIMEOUT_EN
    do_reset();
    pick(4'd6, 4'd1);
    seen = 1'b0;
    repeat (9) begin
      tick();
      if (hide_valid) seen = 1'b1;
    end
    chk("to_early", seen, 0);
    tick();
    chk("to_hide", hide_valid, 1);
    chk("to_idx", {hide_idx_a, hide_idx_b}, 8'h66);
    chk("to_player", player, 1);
    chk("to_state", state, 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
